// File: rtl/vector_issue_queue.sv
// Parametrised valid/ready instruction queue from the scalar scoreboard to vector_top.
// Circular buffer with sequence tags, flush, optional empty-queue bypass and stall counter.
module vector_issue_queue #(
    parameter int unsigned DW       = 96,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 3,
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned BYPASS   = 0,
    parameter int unsigned STALL_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_fifo,
    input  logic [DW-1:0]              instruction,
    output logic                       ready,
    input  logic                       flush,
    output logic                       pop_valid,
    output logic [DW-1:0]              pop_data,
    output logic [TAG_W-1:0]           pop_tag,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic [STALL_W-1:0]         stall_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [DW-1:0]    data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];

    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               af_q;
    logic [STALL_W-1:0] stall_q;

    logic empty;
    logic bypass_path;
    logic push;
    logic bypass_take;
    logic do_write;
    logic do_pop;

    assign empty       = (count_q == '0);
    assign bypass_path = (BYPASS != 0) && empty;
    // ready is independent of pop: a full queue never accepts, even with a same-cycle pop
    assign ready       = (count_q != FULL_CNT) && rst;
    assign push        = valid_fifo && ready && !flush;
    assign bypass_take = bypass_path && push && pop;
    assign do_write    = push && !bypass_take;
    assign do_pop      = pop && !empty && !flush;

    assign pop_valid   = bypass_path ? push : !empty;
    assign pop_data    = bypass_path ? instruction : data_mem[rd_ptr_q];
    assign pop_tag     = bypass_path ? tag_q : tag_mem[rd_ptr_q];

    assign count       = count_q;
    assign almost_full = af_q;
    assign stall_cnt   = stall_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        tag_d    = tag_q + TAG_W'(push);
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(do_write);
            rd_ptr_d = rd_ptr_q + PW'(do_pop);
            count_d  = count_q + CW'(do_write) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            tag_q    <= '0;
            af_q     <= 1'b0;
            stall_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
            af_q     <= (count_d >= AF_CNT);
            if (valid_fifo && !ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; do_write is already low during reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            data_mem[wr_ptr_q] <= instruction;
            tag_mem[wr_ptr_q]  <= tag_q;
        end
    end

endmodule

// File: tb/tb_vector_issue_queue.sv
// Directed bench for vector_issue_queue: one BYPASS=0 and one BYPASS=1 instance.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_vector_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_fifo, flush, pop;
    logic [95:0] instruction;
    logic        ready, pop_valid, almost_full;
    logic [95:0] pop_data;
    logic [7:0]  pop_tag;
    logic [2:0]  count;
    logic [15:0] stall_cnt;

    logic        b_valid, b_flush, b_pop;
    logic [95:0] b_instr;
    logic        b_ready, b_pop_valid, b_af;
    logic [95:0] b_pop_data;
    logic [7:0]  b_pop_tag;
    logic [2:0]  b_count;
    logic [15:0] b_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_issue_queue #(.DW(96), .DEPTH(4), .AF_LEVEL(3), .TAG_W(8), .BYPASS(0), .STALL_W(16)) dut (
        .clk(clk), .rst(rst), .valid_fifo(valid_fifo), .instruction(instruction), .ready(ready),
        .flush(flush), .pop_valid(pop_valid), .pop_data(pop_data), .pop_tag(pop_tag), .pop(pop),
        .count(count), .almost_full(almost_full), .stall_cnt(stall_cnt)
    );

    vector_issue_queue #(.DW(96), .DEPTH(4), .AF_LEVEL(3), .TAG_W(8), .BYPASS(1), .STALL_W(16)) dut_bp (
        .clk(clk), .rst(rst), .valid_fifo(b_valid), .instruction(b_instr), .ready(b_ready),
        .flush(b_flush), .pop_valid(b_pop_valid), .pop_data(b_pop_data), .pop_tag(b_pop_tag),
        .pop(b_pop), .count(b_count), .almost_full(b_af), .stall_cnt(b_stall)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] pat(input int i);
        return {32'hCAFE_0000 + 32'(i), 32'h1234_5678, 32'(i)};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; valid_fifo = 1'b0; flush = 1'b0; pop = 1'b0; instruction = '0;
        b_valid = 1'b0; b_flush = 1'b0; b_pop = 1'b0; b_instr = '0;

        // Reset
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_count", count, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_af", almost_full, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_b_ready", b_ready, 0);
        @(negedge clk); rst = 1'b1; #1;
        check("rel_ready", ready, 1);
        check("rel_b_ready", b_ready, 1);

        // Bypass: consumed directly, then written when not popped
        @(negedge clk); b_valid = 1'b1; b_instr = pat(100); b_pop = 1'b1; #1;
        check("bp_pv", b_pop_valid, 1);
        check("bp_data", b_pop_data, pat(100));
        check("bp_tag", b_pop_tag, 0);
        @(negedge clk); b_pop = 1'b0; b_instr = pat(101); #1;
        check("bp_count0", b_count, 0);
        check("bp_pv2", b_pop_valid, 1);
        check("bp_tag2", b_pop_tag, 1);
        @(negedge clk); b_valid = 1'b0; #1;
        check("bp_count1", b_count, 1);
        check("bp_reg_data", b_pop_data, pat(101));
        check("bp_reg_tag", b_pop_tag, 1);
        @(negedge clk); b_pop = 1'b1; #1;
        check("bp_pop_data", b_pop_data, pat(101));
        @(negedge clk); b_pop = 1'b0; b_flush = 1'b1; b_valid = 1'b1; b_instr = pat(102); #1;
        check("bp_flush_pv", b_pop_valid, 0);
        @(negedge clk); b_flush = 1'b0; b_valid = 1'b0; #1;
        check("bp_flush_count", b_count, 0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); valid_fifo = 1'b1; instruction = pat(i); #1;
            check("fill_count", count, 3'(i));
            check("fill_af", almost_full, i >= 3);
            check("fill_ready", ready, 1);
        end
        @(negedge clk); instruction = pat(99); #1;
        check("full_count", count, 4);
        check("full_af", almost_full, 1);
        check("full_ready", ready, 0);
        repeat (5) @(negedge clk);
        instruction = pat(4); pop = 1'b1; #1;
        check("stall5", stall_cnt, 5);
        check("full_pop_ready", ready, 0);
        check("head_data", pop_data, pat(0));
        check("head_tag", pop_tag, 0);
        @(negedge clk); pop = 1'b0; #1;
        check("after_pop_count", count, 3);
        check("after_pop_ready", ready, 1);
        check("stall6", stall_cnt, 6);
        @(negedge clk); valid_fifo = 1'b0; #1;
        check("refill_count", count, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); pop = 1'b1; #1;
            check("drain_data", pop_data, pat(k + 1));
            check("drain_tag", pop_tag, 8'(k + 1));
        end
        @(negedge clk); pop = 1'b0; #1;
        check("drain_count", count, 0);
        check("drain_pv", pop_valid, 0);
        check("drain_af", almost_full, 0);

        // Steady state at count=2; tag counter is at 5
        @(negedge clk); valid_fifo = 1'b1; instruction = pat(200);
        @(negedge clk); instruction = pat(201);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); instruction = pat(202 + c); pop = 1'b1; #1;
            check("ss_count", count, 2);
            check("ss_data", pop_data, pat(200 + c));
            check("ss_tag", pop_tag, 8'(5 + c));
        end

        // Flush at count=3 with an offered instruction
        @(negedge clk); pop = 1'b0; instruction = pat(222);
        @(negedge clk); flush = 1'b1; instruction = pat(223); #1;
        check("pre_flush_count", count, 3);
        check("flush_ready", ready, 1);
        check("flush_head", pop_data, pat(220));
        @(negedge clk); flush = 1'b0; valid_fifo = 1'b0; #1;
        check("flush_count", count, 0);
        check("flush_pv", pop_valid, 0);
        check("flush_af", almost_full, 0);
        @(negedge clk); valid_fifo = 1'b1; instruction = pat(224);
        @(negedge clk); valid_fifo = 1'b0; #1;
        check("post_flush_count", count, 1);
        check("post_flush_data", pop_data, pat(224));
        check("post_flush_tag", pop_tag, 28);

        // Reset mid-operation at count=3
        @(negedge clk); valid_fifo = 1'b1; instruction = pat(225);
        @(negedge clk); instruction = pat(226);
        @(negedge clk); valid_fifo = 1'b0; #1;
        check("pre_rst_count", count, 3);
        check("pre_rst_stall", stall_cnt, 6);
        @(negedge clk); rst = 1'b0; valid_fifo = 1'b1; instruction = pat(227); #1;
        check("in_rst_ready", ready, 0);
        @(negedge clk); #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_pv", pop_valid, 0);
        check("mid_rst_stall", stall_cnt, 0);
        check("mid_rst_ready", ready, 0);
        @(negedge clk); rst = 1'b1; valid_fifo = 1'b0; #1;
        check("post_rst_ready", ready, 1);
        check("post_rst_count", count, 0);
        @(negedge clk); valid_fifo = 1'b1; instruction = pat(300);
        @(negedge clk); valid_fifo = 1'b0; #1;
        check("post_rst_push_count", count, 1);
        check("post_rst_data", pop_data, pat(300));
        check("post_rst_tag", pop_tag, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_issue_queue.md
Name: vector_issue_queue

Overview:
- Parametrised instruction queue between the scalar scoreboard and vector_top.
- Successor to the fixed 96-bit / depth-4 front FIFO. Adds configurable width and depth, an optional empty-queue bypass, flush, an occupancy count, an almost-full hint, per-instruction sequence tags and a saturating back-pressure stall counter.
- Both sides use valid/ready handshakes; a transfer occurs on any cycle with valid & ready high.

Parameters:
- DW, 96: instruction width in bits (scalar-to-vector payload).
- DEPTH, 4: number of entries; power of two, at least 2.
- AF_LEVEL, 3: almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- TAG_W, 8: sequence tag width.
- BYPASS, 0: 1 enables the zero-latency path when the queue is empty.
- STALL_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- valid_fifo  in  1  scoreboard offers an instruction.
- instruction  in  DW  instruction payload.
- ready  out  1  queue can accept an instruction.
- flush  in  1  discard all queued entries.
- pop_valid  out  1  head entry valid toward vector_top.
- pop_data  out  DW  head instruction.
- pop_tag  out  TAG_W  sequence tag of the head instruction.
- pop  in  1  vector_top accepts the head.
- count  out  $clog2(DEPTH+1)  registered occupancy.
- almost_full  out  1  registered, count >= AF_LEVEL.
- stall_cnt  out  STALL_W  saturating count of back-pressured cycles.

Behaviour:
- Reset
  - While rst=0 at a clk edge, clear: rd_ptr, wr_ptr, count, tag counter, stall_cnt.
  - Resulting outputs: count=0, almost_full=0, stall_cnt=0, pop_valid=0.
  - ready is forced 0 while rst=0 and returns to 1 on the first cycle after release.
  - Reset asserted mid-operation drops all entries; no push or pop takes effect in that cycle.
  - Storage array contents are not reset. pop_data is don't-care while pop_valid=0.
- Storage
  - Circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits; both wrap modulo DEPTH.
  - Full/empty are derived from count, never from pointer equality.
- ready
  - ready = (count != DEPTH) & rst_n, where rst_n is the rst input (active-low: 1 = not in reset).
  - It does not depend on pop, so there is no combinational path from pop to ready.
  - When full, a same-cycle pop does not allow a push.
- Push
  - Condition: valid_fifo & ready & !flush.
  - Writes {instruction, tag} at wr_ptr, then wr_ptr+1 and tag+1. The tag wraps modulo 2^TAG_W.
- Pop, BYPASS=0
  - pop_valid = (count != 0). pop_data/pop_tag = entry at rd_ptr.
  - pop & pop_valid advances rd_ptr.
  - Latency from accepted push to pop_valid: 1 cycle.
  - pop while pop_valid=0 is ignored.
- Pop, BYPASS=1, queue empty
  - pop_valid = valid_fifo & ready; pop_data = instruction; pop_tag = current tag.
  - If pop=1 in that cycle, the instruction is consumed directly: no write, count unchanged, tag still increments.
  - If pop=0, it is written normally.
- Pop, BYPASS=1, queue non-empty: identical to BYPASS=0.
- Count update
  - count_next = count + push_written - pop_from_storage.
  - Simultaneous push and pop at 0 < count < DEPTH leaves count unchanged.
- Flush
  - Has priority over push and pop. On a cycle with flush=1:
    - next-cycle count=0;
    - rd_ptr = wr_ptr;
    - an incoming instruction is not accepted (the scoreboard must retry);
    - any pop handshake in that cycle is still reported to vector_top but has no state effect.
  - The tag counter is not reset by flush, so post-flush tags continue monotonically.
  - In BYPASS mode, pop_valid is forced 0 during flush.
- stall_cnt
  - Increments when valid_fifo & !ready & rst_n.
  - Saturates at 2^STALL_W-1. Cleared only by reset.

Test Plan:
- DEPTH=4, BYPASS=0: reset, then push A,B,C,D on back-to-back cycles with pop=0 → ready=0 after the 4th push, count=4, almost_full=1 from count=3. Pop 4 times → A..D with tags 0..3, count=0.
- Full queue with valid_fifo held 5 cycles → nothing accepted, stall_cnt=5. Then pop once with valid_fifo high → one push the following cycle, count returns to 4.
- Steady state count=2, push and pop every cycle for 20 cycles → count stays 2, data order preserved, pointers wrap 5 times, tags 2..21 observed.
- BYPASS=1, empty queue, push X with pop=1 → pop_valid and pop_data=X in the same cycle, count stays 0. Repeat with pop=0 → X appears registered, count=1.
- count=3, flush=1 together with valid_fifo=1 → next cycle count=0, pop_valid=0, pushed instruction not stored. Next push carries tag = previous tag + 0 (no increment occurred during the flush).
- Reset asserted with count=3 → next cycle count=0, pop_valid=0, stall_cnt=0, ready=0 while rst=0, then ready=1 on the cycle after release.
